// File: rtl/multicore_dispatch.sv
// Multi-core instruction front end: FIFO-buffered masked broadcast plus a signed sum collector.
// Define DISPATCH_PERF_CNT_EN to build the dispatch/stall performance counters.
module multicore_dispatch #(
   parameter int n_core  = 2,
   parameter int inst_bw = 19,
   parameter int mem_bw  = 128,
   parameter int bw_sum  = 24,
   parameter int depth   = 8
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [inst_bw-1:0]                    in_inst,
   input  logic [mem_bw-1:0]                     in_mem,
   input  logic [n_core-1:0]                     in_mask,
   input  logic                                  in_collect,
   output logic [n_core*inst_bw-1:0]             core_inst,
   output logic [mem_bw-1:0]                     core_mem,
   input  logic [n_core*bw_sum-1:0]              core_sum,
   input  logic [n_core-1:0]                     core_sum_valid,
   output logic [bw_sum+$clog2(n_core)-1:0]      sum_out,
   output logic                                  sum_out_valid,
   output logic                                  busy,
   output logic [31:0]                           stall_cnt,
   output logic [31:0]                           disp_cnt
);

   localparam int AW = $clog2(depth);
   localparam int CW = AW + 1;
   localparam int SW = bw_sum + $clog2(n_core);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_DONE
   } col_state_t;

   logic [inst_bw-1:0] r_fifo_inst [depth];
   logic [mem_bw-1:0]  r_fifo_mem  [depth];
   logic [n_core-1:0]  r_fifo_mask [depth];
   logic               r_fifo_col  [depth];

   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [CW-1:0]      r_count;

   logic [n_core*inst_bw-1:0] r_core_inst;
   logic [mem_bw-1:0]         r_core_mem;

   col_state_t         r_state;
   logic [n_core-1:0]  r_cap_mask;
   logic [n_core-1:0]  r_captured;
   logic signed [SW-1:0] r_acc;
   logic [SW-1:0]      r_sum_out;
   logic               r_sum_valid;

   logic               w_push;
   logic               w_empty;
   logic               w_disp;
   logic [inst_bw-1:0] w_head_inst;
   logic [mem_bw-1:0]  w_head_mem;
   logic [n_core-1:0]  w_head_mask;
   logic               w_head_col;
   logic [n_core-1:0]  w_new_cap;
   logic signed [SW-1:0] w_acc_next;
   logic               w_all_done;

   assign in_ready    = (r_count < CW'(depth));
   assign w_push      = in_valid && in_ready;
   assign w_empty     = (r_count == '0);
   assign w_head_inst = r_fifo_inst[r_rd_ptr];
   assign w_head_mem  = r_fifo_mem[r_rd_ptr];
   assign w_head_mask = r_fifo_mask[r_rd_ptr];
   assign w_head_col  = r_fifo_col[r_rd_ptr];

   // A collect head waits until the previous collection has fully retired.
   assign w_disp = !w_empty && !(w_head_col && (r_state != ST_IDLE));

   // NOTE: the FIFO storage has no reset; pointers and count alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_inst[r_wr_ptr] <= in_inst;
         r_fifo_mem[r_wr_ptr]  <= in_mem;
         r_fifo_mask[r_wr_ptr] <= in_mask;
         r_fifo_col[r_wr_ptr]  <= in_collect;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_disp) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_disp})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_core_inst <= '0;
         r_core_mem  <= '0;
      end else begin
         for (int i = 0; i < n_core; i++) begin
            r_core_inst[i*inst_bw +: inst_bw] <= (w_disp && w_head_mask[i]) ? w_head_inst : '0;
         end
         if (w_disp) r_core_mem <= w_head_mem;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_new_cap  = r_cap_mask & core_sum_valid & ~r_captured;
      w_acc_next = r_acc;
      for (int i = 0; i < n_core; i++) begin
         if (w_new_cap[i]) begin
            w_acc_next = w_acc_next + SW'($signed(core_sum[i*bw_sum +: bw_sum]));
         end
      end
   end

   assign w_all_done = ((r_captured | w_new_cap) == r_cap_mask);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_cap_mask  <= '0;
         r_captured  <= '0;
         r_acc       <= '0;
         r_sum_out   <= '0;
         r_sum_valid <= 1'b0;
      end else begin
         r_sum_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_disp && w_head_col) begin
                  r_cap_mask <= w_head_mask;
                  r_captured <= '0;
                  r_acc      <= '0;
                  if (w_head_mask == '0) begin
                     r_state     <= ST_DONE;
                     r_sum_out   <= '0;
                     r_sum_valid <= 1'b1;
                  end else begin
                     r_state <= ST_ARMED;
                  end
               end
            end
            ST_ARMED: begin
               r_captured <= r_captured | w_new_cap;
               r_acc      <= w_acc_next;
               if (w_all_done) begin
                  r_state     <= ST_DONE;
                  r_sum_out   <= w_acc_next;
                  r_sum_valid <= 1'b1;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign core_inst     = r_core_inst;
   assign core_mem      = r_core_mem;
   assign sum_out       = r_sum_out;
   assign sum_out_valid = r_sum_valid;
   assign busy          = !w_empty || (r_state != ST_IDLE);

`ifdef DISPATCH_PERF_CNT_EN
   logic [31:0] r_disp_cnt;
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_disp_cnt  <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_disp)              r_disp_cnt  <= r_disp_cnt + 32'd1;
         if (!w_empty && !w_disp) r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign disp_cnt  = r_disp_cnt;
   assign stall_cnt = r_stall_cnt;
`else
   assign disp_cnt  = '0;
   assign stall_cnt = '0;
`endif

endmodule

// File: doc/multicore_dispatch.md
Name: multicore_dispatch

Overview:
- Instruction front end for the next-generation multi-core chip; replaces the single-core pass-through top.
- Buffers host instructions and memory words in a FIFO and broadcasts each entry to a masked subset of n_core cores, driving NOP (all zeros) to the others.
- Collects per-core signed sum outputs for collect-flagged entries and emits one reduced total per collection.

Parameters:
- n_core, 2, number of attached cores
- inst_bw, 19, instruction word width
- mem_bw, 128, memory data width (pr*bw)
- bw_sum, 24, per-core signed sum width (bw_psum+4)
- depth, 8, FIFO entries (power of two, >=2)

Ports:
- clk  input  1  clock, rising-edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  host entry valid
- in_ready  output  1  FIFO can accept an entry
- in_inst  input  inst_bw  instruction word
- in_mem  input  mem_bw  memory data bundled with the instruction
- in_mask  input  n_core  target cores
- in_collect  input  1  entry arms a sum collection over in_mask
- core_inst  output  n_core*inst_bw  per-core instruction; core i at slice i
- core_mem  output  mem_bw  shared memory data to all cores
- core_sum  input  n_core*bw_sum  per-core signed sums
- core_sum_valid  input  n_core  per-core sum strobe
- sum_out  output  bw_sum+$clog2(n_core)  reduced signed total
- sum_out_valid  output  1  one-cycle pulse with sum_out
- busy  output  1  FIFO non-empty or collection armed
- stall_cnt  output  32  perf counter, see Optional Feature
- disp_cnt  output  32  perf counter, see Optional Feature

Behaviour:
- Reset (reset low, asynchronous) clears FIFO pointers, count, collector and all outputs to 0. After reset release, in_ready=1.
- in_ready = (count < depth), taken from a registered count.
- Push occurs when in_valid && in_ready; there is no bypass.
- Dispatch condition on a cycle: FIFO non-empty AND NOT (head.collect AND collector armed).
- On dispatch, at the next edge:
  - core_inst slice i = head.inst if mask[i], else 0.
  - core_mem = head.mem.
  - The head is popped.
- Non-dispatch cycle: all core_inst slices are 0 at the next edge; core_mem holds its value.
- Latency: an entry pushed at edge t is dispatched at edge t+1 when the FIFO was empty.
- Push and pop on the same edge leave count unchanged. A push while full is impossible because in_ready is low.
- Collector FSM:
  - IDLE -> ARMED on dispatch of a collect entry with nonzero mask. Capture mask M, clear the captured vector and the accumulators.
  - ARMED: for each i in M with core_sum_valid[i] and not yet captured, capture core_sum slice i, sign-extended. Strobes from cores outside M, or already captured, are ignored. Strobes from cores in M are not considered in the dispatch cycle itself.
  - ARMED -> DONE when every bit of M is captured, counting captures made this cycle.
  - DONE: sum_out = signed sum of the captured values; sum_out_valid = 1 for exactly one cycle; then IDLE.
  - sum_out holds its value until the next DONE.
  - A collect entry with mask == 0 goes directly to DONE: sum_out = 0, pulse next cycle.
- A head collect entry can dispatch only while the collector is IDLE, i.e. at the earliest on the edge after sum_out_valid's cycle. Non-collect entries dispatch freely while ARMED.
- Arithmetic: two's complement throughout; the output width grows by $clog2(n_core), so there is no overflow or saturation.
- busy = (count != 0) || (collector != IDLE).
- Reset mid-collection discards partial captures; no sum_out_valid pulse is emitted.

Optional Feature:
- Macro: DISPATCH_PERF_CNT_EN.
- Defined:
  - disp_cnt increments on every dispatch.
  - stall_cnt increments on each cycle the FIFO is non-empty but the dispatch condition is false.
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: both ports are tied to 0 and no counter logic is generated.

Test Plan:
- Reset then single push (inst=19'h12345, mask=2'b10, collect=0) -> one edge later core_inst[37:19]=19'h12345, core_inst[18:0]=0; following cycle all 0.
- Push 9 entries back-to-back, depth=8, with dispatch blocked by an ARMED collector and a collect head -> in_ready=0 after 8; the 9th is held by the host; entries dispatch in order once unblocked.
- Collect mask=2'b11; core 0 strobes -5 at cycle 3, core 1 strobes 1000 at cycle 6 -> sum_out=995, sum_out_valid high for exactly one cycle at cycle 7.
- Second collect entry queued behind an armed collection; non-collect entries queued after it -> those entries wait behind the FIFO head; the second collect dispatches the edge after sum_out_valid.
- Collect with mask=0 -> sum_out=0 with a pulse one cycle after dispatch. Stray core_sum_valid while IDLE -> no effect.
- Assert reset low mid-collection -> all outputs 0 asynchronously; no pulse after release. With DISPATCH_PERF_CNT_EN defined, disp_cnt/stall_cnt match the bench's dispatch and stall counts.
